// File: rtl/mmio_fifo_csr.sv
// mmio_fifo_csr
// MMIO-mapped FIFO with status, control, sticky error flags and flush.
// Decoded CCI-P c0 MMIO strobes push/pop words; every hit read gets a
// registered one-cycle-latency response for the Tx c2 response mux.
//
// Register window (dword addresses relative to BASE_ADDR):
//   +0 DATA    W: push wdata[DATA_W-1:0]      R: pop head (0 and udf when empty)
//   +2 STATUS  R: [0]empty [1]full [2]ovf [3]udf [31:16]count [47:32]DEPTH
//   +4 CTRL    W: bit0 flush, bit1 clear ovf/udf   R: 0
//   +6 PEEK    R: head word without popping (only with MMIO_FIFO_PEEK_EN), else 0
//
// Build option: define MMIO_FIFO_PEEK_EN to synthesise the PEEK read path.
module mmio_fifo_csr #(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 8,
   parameter logic [15:0] BASE_ADDR = 16'h0020
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mmio_wr,
   input  logic                       mmio_rd,
   input  logic [15:0]                mmio_addr,
   input  logic [8:0]                 mmio_tid,
   input  logic [63:0]                mmio_wdata,
   output logic                       rsp_valid,
   output logic [8:0]                 rsp_tid,
   output logic [63:0]                rsp_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int          PTR_W   = $clog2(DEPTH);
   localparam int          CNT_W   = $clog2(DEPTH+1);
   localparam logic [15:0] DEPTH16 = 16'(DEPTH);

   // Register index inside the window, taken from dword offset bits [2:1].
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_PEEK   = 2'd3
   } reg_e;

   // Storage and pointer state.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              ovf;
   logic              udf;

   // Address decode.
   logic [15:0] offset;
   logic        hit;
   reg_e        sel;

   // Per-cycle events.
   logic        wr_data;
   logic        rd_data;
   logic        rd_hit;
   logic        wr_ctrl;
   logic        flush;
   logic        clr_err;
   logic        do_pop;
   logic        do_push;
   logic        ovf_evt;
   logic        udf_evt;
   logic [CNT_W-1:0]  count_next;
   logic [DATA_W-1:0] head;
   logic [63:0]       head_ext;
   logic [63:0]       status_word;
   logic [63:0]       rd_word;

   // Upper write-data bits are only meaningful for some registers/widths.
   logic unused_wdata;
   assign unused_wdata = ^mmio_wdata;

   // Offset wraps for addresses below BASE_ADDR, so those never hit.
   assign offset = mmio_addr - BASE_ADDR;
   assign hit    = (offset[15:3] == 13'd0) && !offset[0];
   assign sel    = reg_e'(offset[2:1]);

   assign wr_data = mmio_wr && hit && (sel == REG_DATA);
   assign rd_data = mmio_rd && hit && (sel == REG_DATA);
   assign rd_hit  = mmio_rd && hit;
   assign wr_ctrl = mmio_wr && hit && (sel == REG_CTRL);
   assign flush   = wr_ctrl && mmio_wdata[0];
   assign clr_err = wr_ctrl && mmio_wdata[1];

   // Occupancy flags come straight from the registered count.
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A pop from a full FIFO frees the slot a same-cycle push needs, so a
   // push is only refused when full and nothing leaves this cycle.
   assign do_pop  = rd_data && !empty;
   assign udf_evt = rd_data && empty;
   assign do_push = wr_data && (!full || do_pop);
   assign ovf_evt = wr_data && full && !do_pop;

   assign head     = mem[rd_ptr];
   assign head_ext = 64'(head);

   // Snapshot of state before any same-cycle update.
   assign status_word = {16'h0000, DEPTH16, 16'(count), 12'h000, udf, ovf, full, empty};

   // Next occupancy from the push/pop pair.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      count_next = count;
      unique case ({do_push, do_pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Read-data mux for whichever register the hit read selects.
   always_comb begin
      rd_word = 64'h0;
      unique case (sel)
         REG_DATA:   rd_word = empty ? 64'h0 : head_ext;
         REG_STATUS: rd_word = status_word;
         REG_CTRL:   rd_word = 64'h0;
`ifdef MMIO_FIFO_PEEK_EN
         REG_PEEK:   rd_word = empty ? 64'h0 : head_ext;
`else
         REG_PEEK:   rd_word = 64'h0;
`endif
         default:    rd_word = 64'h0;
      endcase
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; pointers and count alone
      // decide which entries are valid, and this keeps it mappable to RAM.
      if (do_push) begin
         mem[wr_ptr] <= mmio_wdata[DATA_W-1:0];
      end
   end

   // Pointers, occupancy and sticky error flags; flush overrides the push/pop.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
         end
         // A new event in the same cycle as a clear leaves the flag set.
         ovf <= ovf_evt || (ovf && !clr_err);
         udf <= udf_evt || (udf && !clr_err);
      end
   end

   // Registered read response: one-cycle valid pulse, tid/data held until next hit read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_hit;
         if (rd_hit) begin
            rsp_tid  <= mmio_tid;
            rsp_data <= rd_word;
         end
      end
   end

endmodule
